// File: rtl/gpr_pkg.sv
// Purpose: shared constants for the GPR file (default geometry and FSM state encodings).
// Ports  : none (package).
package gpr_pkg;

   localparam int unsigned GPR_DATA_WIDTH = 16;
   localparam int unsigned GPR_ADDR_WIDTH = 3;
   localparam int unsigned GPR_DEPTH      = 8;

   // Transaction FSM states
   localparam int unsigned GPR_ST_W  = 2;
   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_ACCESS = 2'd1;
   localparam logic [1:0]  ST_DONE   = 2'd2;

endpackage : gpr_pkg

// File: rtl/gpr_bank.sv
// Purpose: DEPTH x DATA_WIDTH register storage, one synchronous write port and two
//          combinational read ports, with range checking and optional hardwired-zero R0.
// Ports  : clk, rst         - clock, synchronous active-high reset (clears storage)
//          wr_en            - a write is requested by the current transaction
//          wr_commit        - strobe: commit the write at this clock edge
//          waddr, wdata     - write address / data
//          raddr_a, raddr_b - read addresses
//          rdata_a_c/_b_c   - combinational read data (0 for out-of-range or masked R0)
//          wr_ok_c          - the requested write is legal and will land in storage
//          range_err_c      - some used address is outside the populated range
module gpr_bank
   import gpr_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
   parameter int unsigned DEPTH      = GPR_DEPTH,
   parameter int unsigned ZERO_REG   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  wr_commit,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr_a,
   input  logic [ADDR_WIDTH-1:0] raddr_b,
   output logic [DATA_WIDTH-1:0] rdata_a_c,
   output logic [DATA_WIDTH-1:0] rdata_b_c,
   output logic                  wr_ok_c,
   output logic                  range_err_c
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic waddr_oob;
   logic raddr_a_oob;
   logic raddr_b_oob;
   logic waddr_zero_drop;

   // Range and R0 qualification
   always_comb begin
      waddr_oob       = (32'(waddr)   >= DEPTH);
      raddr_a_oob     = (32'(raddr_a) >= DEPTH);
      raddr_b_oob     = (32'(raddr_b) >= DEPTH);
      waddr_zero_drop = (ZERO_REG != 0) && (waddr == '0);
      wr_ok_c         = wr_en && !waddr_oob && !waddr_zero_drop;
      range_err_c     = (wr_en && waddr_oob) || raddr_a_oob || raddr_b_oob;
   end

   // Storage: address decode by loop keeps every index inside the populated range
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (wr_commit && wr_ok_c) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (waddr == ADDR_WIDTH'(i)) mem[i] <= wdata;
         end
      end
   end

   // Read ports: unmatched (out-of-range) addresses and masked R0 fall through to 0
   always_comb begin
      rdata_a_c = '0;
      rdata_b_c = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if ((ZERO_REG == 0) || (i != 0)) begin
            if (raddr_a == ADDR_WIDTH'(i)) rdata_a_c = mem[i];
            if (raddr_b == ADDR_WIDTH'(i)) rdata_b_c = mem[i];
         end
      end
   end

endmodule : gpr_bank

// File: rtl/gpr_file.sv
// Purpose: 1W/2R general-purpose register file with a req/rdy transaction FSM
//          (IDLE -> ACCESS -> DONE), input capture, optional write->read bypass and
//          registered read data / status.
// Ports  : clk, rst          - clock, synchronous active-high reset
//          cs, req           - chip select and request; accepted only while rdy=1
//          write, waddr, wdata - write request, address, data
//          raddr_a, raddr_b  - read addresses
//          rdata_a, rdata_b  - registered read data, valid while valid=1, held afterwards
//          rdy               - idle, able to accept a request
//          valid             - one-cycle completion pulse
//          err               - pulses with valid when any used address is out of range
module gpr_file
   import gpr_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
   parameter int unsigned DEPTH      = GPR_DEPTH,
   parameter int unsigned ZERO_REG   = 0,
   parameter int unsigned BYPASS     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic                  req,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr_a,
   input  logic [ADDR_WIDTH-1:0] raddr_b,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic [DATA_WIDTH-1:0] rdata_b,
   output logic                  rdy,
   output logic                  valid,
   output logic                  err
);

   logic [GPR_ST_W-1:0]   state;
   logic [GPR_ST_W-1:0]   state_d;

   // Transaction fields captured at the accept edge
   logic                  cap_write;
   logic [ADDR_WIDTH-1:0] cap_waddr;
   logic [DATA_WIDTH-1:0] cap_wdata;
   logic [ADDR_WIDTH-1:0] cap_raddr_a;
   logic [ADDR_WIDTH-1:0] cap_raddr_b;

   logic                  cap_en;
   logic                  load_en;
   logic                  commit;
   logic                  rdy_d;
   logic                  valid_d;
   logic                  err_d;
   logic [DATA_WIDTH-1:0] rd_a_nxt;
   logic [DATA_WIDTH-1:0] rd_b_nxt;

   logic [DATA_WIDTH-1:0] bank_rdata_a;
   logic [DATA_WIDTH-1:0] bank_rdata_b;
   logic                  bank_wr_ok;
   logic                  bank_range_err;

   gpr_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .ZERO_REG   (ZERO_REG)
   ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (cap_write),
      .wr_commit   (commit),
      .waddr       (cap_waddr),
      .wdata       (cap_wdata),
      .raddr_a     (cap_raddr_a),
      .raddr_b     (cap_raddr_b),
      .rdata_a_c   (bank_rdata_a),
      .rdata_b_c   (bank_rdata_b),
      .wr_ok_c     (bank_wr_ok),
      .range_err_c (bank_range_err)
   );

   // Bypass only forwards writes that actually land; dropped writes read storage
   always_comb begin
      rd_a_nxt = bank_rdata_a;
      rd_b_nxt = bank_rdata_b;
      if ((BYPASS != 0) && bank_wr_ok) begin
         if (cap_waddr == cap_raddr_a) rd_a_nxt = cap_wdata;
         if (cap_waddr == cap_raddr_b) rd_b_nxt = cap_wdata;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state;
      cap_en  = 1'b0;
      load_en = 1'b0;
      commit  = 1'b0;
      rdy_d   = 1'b0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cs && req) begin
               cap_en  = 1'b1;
               state_d = ST_ACCESS;
            end else begin
               rdy_d   = 1'b1;
            end
         end
         ST_ACCESS: begin
            commit  = 1'b1;
            load_en = 1'b1;
            valid_d = 1'b1;
            err_d   = bank_range_err;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, capture and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rdy         <= 1'b1;
         valid       <= 1'b0;
         err         <= 1'b0;
         rdata_a     <= '0;
         rdata_b     <= '0;
         cap_write   <= 1'b0;
         cap_waddr   <= '0;
         cap_wdata   <= '0;
         cap_raddr_a <= '0;
         cap_raddr_b <= '0;
      end else begin
         state <= state_d;
         rdy   <= rdy_d;
         valid <= valid_d;
         err   <= err_d;
         if (cap_en) begin
            cap_write   <= write;
            cap_waddr   <= waddr;
            cap_wdata   <= wdata;
            cap_raddr_a <= raddr_a;
            cap_raddr_b <= raddr_b;
         end
         if (load_en) begin
            rdata_a <= rd_a_nxt;
            rdata_b <= rd_b_nxt;
         end
      end
   end

endmodule : gpr_file

// File: tb/tb_gpr_file.sv
// Purpose: directed self-checking bench for gpr_file. Two instances share stimulus:
//          u_dut0 uses the default geometry (8 regs, no R0 masking, no bypass),
//          u_dut1 uses DEPTH=6, ZERO_REG=1, BYPASS=1.
module tb_gpr_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs;
   logic        req;
   logic        write;
   logic [2:0]  waddr;
   logic [15:0] wdata;
   logic [2:0]  raddr_a;
   logic [2:0]  raddr_b;

   logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
   logic        rdy0, valid0, err0, rdy1, valid1, err1;

   int n_cmp = 0;
   int n_bad = 0;

   // err captured during the valid cycle of the last transaction
   logic cap_err0, cap_err1;

   always #5 clk = ~clk;

   gpr_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) u_dut0 (
      .clk(clk), .rst(rst), .cs(cs), .req(req), .write(write), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
      .rdy(rdy0), .valid(valid0), .err(err0));

   gpr_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(6), .ZERO_REG(1), .BYPASS(1)) u_dut1 (
      .clk(clk), .rst(rst), .cs(cs), .req(req), .write(write), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
      .rdy(rdy1), .valid(valid1), .err(err1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One transaction; called and returns at a negedge. Inputs are scrambled after the
   // accept edge to show they are no longer sampled.
   task automatic run_txn(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                          input logic [2:0] ra, input logic [2:0] rb);
      int n = 0;
      while (!(rdy0 && rdy1) && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) chk("rdy_timeout", 32'(rdy0 & rdy1), 32'd1);
      cs = 1'b1; req = 1'b1; write = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
      @(posedge clk);
      @(negedge clk);
      chk("access_rdy0", 32'(rdy0), 32'd0);
      chk("access_valid0", 32'(valid0), 32'd0);
      write = 1'b1; waddr = 3'd1; wdata = 16'hDEAD; raddr_a = ~ra; raddr_b = ~rb;
      @(negedge clk);
      chk("done_valid0", 32'(valid0), 32'd1);
      chk("done_valid1", 32'(valid1), 32'd1);
      cap_err0 = err0;
      cap_err1 = err1;
      cs = 1'b0; req = 1'b0; write = 1'b0;
      @(negedge clk);
      chk("post_rdy0", 32'(rdy0), 32'd1);
      chk("post_valid1", 32'(valid1), 32'd0);
   endtask

   task automatic expect_rd(input string tag,
                            input logic [15:0] a0, input logic [15:0] b0, input logic e0,
                            input logic [15:0] a1, input logic [15:0] b1, input logic e1);
      chk({tag, "_a0"}, 32'(rdata_a0), 32'(a0));
      chk({tag, "_b0"}, 32'(rdata_b0), 32'(b0));
      chk({tag, "_e0"}, 32'(cap_err0), 32'(e0));
      chk({tag, "_a1"}, 32'(rdata_a1), 32'(a1));
      chk({tag, "_b1"}, 32'(rdata_b1), 32'(b1));
      chk({tag, "_e1"}, 32'(cap_err1), 32'(e1));
   endtask

   initial begin
      int vcnt0, vcnt1;
      rst = 1'b1; cs = 1'b0; req = 1'b0; write = 1'b0;
      waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

      // Reset
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("rst_rdy0", 32'(rdy0), 32'd1);
      chk("rst_rdy1", 32'(rdy1), 32'd1);
      chk("rst_valid0", 32'(valid0), 32'd0);
      chk("rst_err1", 32'(err1), 32'd0);
      chk("rst_rdata_a0", 32'(rdata_a0), 32'd0);
      chk("rst_rdata_b1", 32'(rdata_b1), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         run_txn(1'b0, 3'd0, 16'h0, 3'(i), 3'(i));
         expect_rd("rst_read", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, (i >= 6));
      end

      // Write then read R3
      run_txn(1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd3);
      expect_rd("wr3", 16'h0, 16'h0, 1'b0, 16'hA5A5, 16'hA5A5, 1'b0);
      run_txn(1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
      expect_rd("rd3", 16'hA5A5, 16'hA5A5, 1'b0, 16'hA5A5, 16'hA5A5, 1'b0);
      run_txn(1'b0, 3'd0, 16'h0, 3'd1, 3'd3);
      expect_rd("rd1_scramble", 16'h0, 16'hA5A5, 1'b0, 16'h0, 16'hA5A5, 1'b0);

      // Same-transaction read of the written address
      run_txn(1'b1, 3'd5, 16'h1111, 3'd0, 3'd0);
      expect_rd("wr5a", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
      run_txn(1'b1, 3'd5, 16'h2222, 3'd5, 3'd3);
      expect_rd("byp5", 16'h1111, 16'hA5A5, 1'b0, 16'h2222, 16'hA5A5, 1'b0);

      // R0 handling
      run_txn(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd5);
      expect_rd("wr0", 16'h0, 16'h2222, 1'b0, 16'h0, 16'h2222, 1'b0);
      run_txn(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
      expect_rd("rd0", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 16'h0, 1'b0);

      // Out-of-range on the DEPTH=6 instance
      run_txn(1'b1, 3'd7, 16'h1234, 3'd2, 3'd7);
      expect_rd("wr7", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
      run_txn(1'b0, 3'd0, 16'h0, 3'd7, 3'd6);
      expect_rd("rd7", 16'h1234, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);

      // req held high: one accept every third cycle
      vcnt0 = 0; vcnt1 = 0;
      cs = 1'b1; req = 1'b1; write = 1'b0; raddr_a = 3'd3; raddr_b = 3'd5;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (valid0) begin
            vcnt0++;
            chk("hold_rdata_b0", 32'(rdata_b0), 32'h2222);
         end
         if (valid1) vcnt1++;
      end
      req = 1'b0;
      chk("hold_valid_cnt0", 32'(vcnt0), 32'd3);
      chk("hold_valid_cnt1", 32'(vcnt1), 32'd3);
      @(negedge clk); @(negedge clk);

      // req without cs is ignored
      vcnt0 = 0;
      cs = 1'b0; req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (valid0 || !rdy0) vcnt0++;
      end
      req = 1'b0;
      chk("nocs_activity", 32'(vcnt0), 32'd0);

      // Reset during ACCESS aborts the write
      cs = 1'b1; req = 1'b1; write = 1'b1; waddr = 3'd2; wdata = 16'hBEEF;
      raddr_a = 3'd2; raddr_b = 3'd2;
      @(posedge clk);
      @(negedge clk);
      chk("abort_in_access", 32'(rdy0), 32'd0);
      rst = 1'b1; cs = 1'b0; req = 1'b0; write = 1'b0;
      @(negedge clk);
      chk("abort_rdy0", 32'(rdy0), 32'd1);
      chk("abort_valid0", 32'(valid0), 32'd0);
      chk("abort_valid1", 32'(valid1), 32'd0);
      chk("abort_rdata_b0", 32'(rdata_b0), 32'd0);
      rst = 1'b0;
      run_txn(1'b0, 3'd0, 16'h0, 3'd2, 3'd3);
      expect_rd("abort_rd2", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule : tb_gpr_file
